// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and default widths for the FIFO burst reader.
package fifo_pkg;
    localparam int FIFO_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF  = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_e;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: command, FIFO read port and output stream of the burst reader.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int FW = FIFO_WIDTH_DEF,
    parameter int LW = LEN_WIDTH_DEF
) ();
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready;
    logic          rd_en;
    logic [FW-1:0] data_out;
    logic          empty;
    logic          underflow;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          done;
    logic          err_underflow;
    modport master (
        input  cmd_valid, cmd_len, data_out, empty, underflow, out_ready,
        output cmd_ready, rd_en, out_valid, out_data, out_last, done, err_underflow
    );
    modport slave (
        output cmd_valid, cmd_len, data_out, empty, underflow, out_ready,
        input  cmd_ready, rd_en, out_valid, out_data, out_last, done, err_underflow
    );
endinterface

// File: rtl/fifo_skid_buf2.sv
// fifo_skid_buf2: 2-entry in-order buffer; head entry is always e0.
module fifo_skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d, cnt_p;
    logic pop_ok;
    // Pop is applied first, so a push lands in whichever slot the pop left free.
    always_comb begin
        pop_ok = pop && cnt_q != 2'd0;
        cnt_p  = cnt_q - {1'b0, pop_ok};
        cnt_d  = cnt_p + {1'b0, push};
        e0_d   = (push && cnt_p == 2'd0) ? push_data : (pop_ok ? e1_q : e0_q);
        e1_d   = (push && cnt_p != 2'd0) ? push_data : e1_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end
    assign count      = cnt_q;
    assign head_data  = e0_q;
    assign head_valid = cnt_q != 2'd0;
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a commanded number of FIFO words onto a valid/ready stream.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input logic clk,
    input logic rst_n,
    fifo_burst_reader_if.master bus
);
    rd_state_e state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, issued_q, issued_d, sent_q, sent_d;
    logic inflight_q, err_q;
    logic [1:0] count;
    logic [2:0] credit_used;
    logic pop, head_valid, drain_done;
    logic [FIFO_WIDTH-1:0] head_data;

    fifo_skid_buf2 #(.WIDTH(FIFO_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.data_out),
        .pop       (pop),
        .count     (count),
        .head_data (head_data),
        .head_valid(head_valid)
    );

    assign pop               = head_valid && bus.out_ready;
    assign bus.out_valid     = head_valid;
    assign bus.out_data      = head_data;
    assign bus.out_last      = head_valid && (sent_q == len_q - 1'b1);
    assign bus.cmd_ready     = state_q == IDLE;
    assign bus.done          = state_q == DONE;
    assign bus.err_underflow = err_q;
    // The word leaving this cycle frees its slot, which keeps one read per clock.
    assign credit_used = {1'b0, count} - {2'b00, pop} + {2'b00, inflight_q};
    assign bus.rd_en   = state_q == RUN && !bus.empty && issued_q < len_q && credit_used < 3'd2;
    assign drain_done  = !inflight_q &&
                         ((sent_q == len_q && count == 2'd0) || (bus.out_last && pop && count == 2'd1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q + LEN_WIDTH'(bus.rd_en);
        sent_d   = sent_q + LEN_WIDTH'(pop);
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                len_d    = bus.cmd_len;
                issued_d = '0;
                sent_d   = '0;
                state_d  = bus.cmd_len == '0 ? DONE : RUN;
            end
            RUN:     state_d = issued_q == len_q ? DRAIN : RUN;
            DRAIN:   state_d = drain_done ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= bus.rd_en;
            err_q      <= err_q | (bus.underflow && bus.rd_en);
        end
    end
endmodule
